tpu_result_serializer: RTL and testbench

Downstream stage of the `tpu` core. Captures one N×N block of accumulator results in a single cycle and streams it to the Tiny Tapeout pads one byte at a time. The host paces the transfer with a read strobe on a bidirectional pin. Sits between the systolic array's result bus and the `out_ui`/`out_uio` drive in the top-level wrapper.

---
 rtl/tpu_pkg.sv | 22 ++
 rtl/tpu_result_serializer_if.sv | 25 ++
 rtl/tpu_sync_edge.sv | 24 ++
 rtl/tpu_result_serializer.sv | 112 +++++++++++
 tb/tb_tpu_result_serializer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the tpu core's datapath stages.
package tpu_pkg;

  localparam int unsigned NDefault    = 2;
  localparam int unsigned AccWDefault = 16;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

  // Callers sign-extend their ACC_W-bit accumulator to 32 bits first.
  function automatic logic [7:0] sat8(input logic signed [31:0] v);
    if (v > 32'sd127) begin
      return 8'h7F;
    end else if (v < -32'sd128) begin
      return 8'h80;
    end
    return v[7:0];
  endfunction

endpackage

// File: rtl/tpu_result_serializer_if.sv
// Result bus from the systolic array: one-cycle valid pulse with a packed N*N block.
interface tpu_result_serializer_if
  import tpu_pkg::*;
#(
  parameter int unsigned N     = NDefault,
  parameter int unsigned ACC_W = AccWDefault
);

  logic                   res_valid;
  logic [N*N*ACC_W-1:0]   res_data;
  logic                   res_ready;

  modport master (
    output res_valid,
    output res_data,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    output res_ready
  );

endinterface

// File: rtl/tpu_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input plus a one-cycle rising-edge pulse.
module tpu_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/tpu_result_serializer.sv
// Captures one N*N accumulator block and streams it out a byte per host read strobe.
module tpu_result_serializer
  import tpu_pkg::*;
#(
  parameter int unsigned N     = NDefault,
  parameter int unsigned ACC_W = AccWDefault,
  parameter bit          SAT8  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  tpu_result_serializer_if.slave res_bus,
  input  logic                   host_rd,
  input  logic                   ovf_clr,
  output logic [7:0]             data_out,
  output logic                   data_avail,
  output logic                   last_byte,
  output logic                   overflow
);

  localparam int unsigned NumEl      = N * N;
  localparam int unsigned BytesPerEl = SAT8 ? 1 : ACC_W / 8;
  localparam int unsigned NumBytes   = NumEl * BytesPerEl;
  localparam int unsigned IdxW       = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned DataW      = NumEl * ACC_W;
  localparam int unsigned SelW       = (DataW > 1) ? $clog2(DataW) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

  ser_state_t       state_q, state_d;
  logic [DataW-1:0] hold_q, hold_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic             rd_rise;
  logic [7:0]       byte_sel;
  logic [SelW-1:0]  sel_base;

  tpu_sync_edge u_rd_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (host_rd),
    .rise (rd_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (res_bus.res_valid) begin
          hold_d  = res_bus.res_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A block offered while busy is lost; the drop outranks a same-cycle clear.
        if (res_bus.res_valid) begin
          ovf_d = 1'b1;
        end
        if (rd_rise) begin
          if (idx_q == LastIdx) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
    endcase
  end

  if (SAT8) begin : g_sat
    logic signed [ACC_W-1:0] elem;
    logic signed [31:0]      elem_ext;

    assign sel_base = SelW'(idx_q) * SelW'(ACC_W);

    always_comb begin
      elem     = hold_q[sel_base +: ACC_W];
      elem_ext = elem;
      byte_sel = sat8(elem_ext);
    end
  end else begin : g_raw
    // Elements are packed LSB-first, so byte k of the stream is simply bits [8k +: 8].
    assign sel_base = SelW'(idx_q) * SelW'(8);
    assign byte_sel = hold_q[sel_base +: 8];
  end

  assign data_avail        = (state_q == SEND);
  assign res_bus.res_ready = (state_q == IDLE);
  assign data_out          = data_avail ? byte_sel : 8'h00;
  assign last_byte         = data_avail && (idx_q == LastIdx);
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_tpu_result_serializer.sv
// Directed bench: raw and saturated byte streams, overflow, async reset and strobe timing.
module tb_tpu_result_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_rd;
  logic       ovf_clr;
  logic [7:0] dout0, dout1;
  logic       avail0, avail1, last0, last1, ovf0, ovf1;

  int n_cmp = 0;
  int n_err = 0;

  tpu_result_serializer_if #(.N(2), .ACC_W(16)) bus0 ();
  tpu_result_serializer_if #(.N(2), .ACC_W(16)) bus1 ();

  tpu_result_serializer #(.N(2), .ACC_W(16), .SAT8(1'b0)) dut_raw (
    .clk        (clk),
    .rst        (rst),
    .res_bus    (bus0),
    .host_rd    (host_rd),
    .ovf_clr    (ovf_clr),
    .data_out   (dout0),
    .data_avail (avail0),
    .last_byte  (last0),
    .overflow   (ovf0)
  );

  tpu_result_serializer #(.N(2), .ACC_W(16), .SAT8(1'b1)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .res_bus    (bus1),
    .host_rd    (host_rd),
    .ovf_clr    (ovf_clr),
    .data_out   (dout1),
    .data_avail (avail1),
    .last_byte  (last1),
    .overflow   (ovf1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One host read: high for 4 cycles, low for 4 cycles; starts and ends on a negedge.
  task automatic strobe();
    host_rd = 1'b1;
    repeat (4) @(negedge clk);
    host_rd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] exp_a [8] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'hFF};
  logic [7:0] exp_b [4] = '{8'h7F, 8'h80, 8'h05, 8'hFB};

  initial begin
    logic [7:0] prev;
    int         changes;
    int         lat;
    int         k;

    rst = 1'b1;
    host_rd = 1'b0;
    ovf_clr = 1'b0;
    bus0.res_valid = 1'b0;
    bus0.res_data  = '0;
    bus1.res_valid = 1'b0;
    bus1.res_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", 32'(bus0.res_ready), 1);
    check("rst_dout", 32'(dout0), 0);
    check("rst_avail", 32'(avail0), 0);
    check("rst_last", 32'(last0), 0);
    check("rst_ovf", 32'(ovf0), 0);

    // Raw 16-bit block, with a dropped block offered during byte 3.
    bus0.res_valid = 1'b1;
    bus0.res_data  = 64'hFFFF_0001_ABCD_1234;
    @(negedge clk);
    bus0.res_valid = 1'b0;
    check("a_ready_busy", 32'(bus0.res_ready), 0);
    check("a_avail", 32'(avail0), 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a_byte%0d", i), 32'(dout0), 32'(exp_a[i]));
      check($sformatf("a_last%0d", i), 32'(last0), 32'(i == 7));
      if (i == 2) begin
        bus0.res_valid = 1'b1;
        bus0.res_data  = 64'h5555_5555_5555_5555;
        @(negedge clk);
        bus0.res_valid = 1'b0;
        check("a_ovf_set", 32'(ovf0), 1);
        check("a_byte2_kept", 32'(dout0), 32'hCD);
      end
      strobe();
    end
    check("a_end_avail", 32'(avail0), 0);
    check("a_end_ready", 32'(bus0.res_ready), 1);
    check("a_end_dout", 32'(dout0), 0);
    check("a_end_ovf", 32'(ovf0), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("a_ovf_clr", 32'(ovf0), 0);

    // Saturating instance.
    bus1.res_valid = 1'b1;
    bus1.res_data  = 64'hFFFB_0005_FF00_0200;
    @(negedge clk);
    bus1.res_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_byte%0d", i), 32'(dout1), 32'(exp_b[i]));
      check($sformatf("b_last%0d", i), 32'(last1), 32'(i == 3));
      strobe();
    end
    check("b_end_avail", 32'(avail1), 0);
    check("b_end_ready", 32'(bus1.res_ready), 1);
    check("b_ovf", 32'(ovf1), 0);

    // Clear and drop in the same cycle, then asynchronous reset after two bytes.
    bus0.res_valid = 1'b1;
    bus0.res_data  = 64'h8877_6655_4433_2211;
    @(negedge clk);
    bus0.res_valid = 1'b0;
    check("c_byte0", 32'(dout0), 32'h11);
    bus0.res_valid = 1'b1;
    bus0.res_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    ovf_clr = 1'b1;
    @(negedge clk);
    bus0.res_valid = 1'b0;
    ovf_clr = 1'b0;
    check("c_ovf_set_wins", 32'(ovf0), 1);
    check("c_byte0_kept", 32'(dout0), 32'h11);
    strobe();
    strobe();
    check("c_byte2", 32'(dout0), 32'h33);
    #2;
    rst = 1'b1;
    #1;
    check("c_rst_avail", 32'(avail0), 0);
    check("c_rst_ready", 32'(bus0.res_ready), 1);
    check("c_rst_dout", 32'(dout0), 0);
    check("c_rst_last", 32'(last0), 0);
    check("c_rst_ovf", 32'(ovf0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus0.res_valid = 1'b1;
    bus0.res_data  = 64'h0F0E_0D0C_0B0A_0908;
    @(negedge clk);
    bus0.res_valid = 1'b0;
    check("c_new_byte0", 32'(dout0), 32'h08);

    // Strobe at an arbitrary phase: exactly one advance, 3-4 edges after the rise.
    @(posedge clk);
    #3;
    host_rd = 1'b1;
    prev = dout0;
    changes = 0;
    lat = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (dout0 !== prev) begin
        changes++;
        if (lat == 0) lat = e;
        prev = dout0;
      end
    end
    host_rd = 1'b0;
    check("d_changes", 32'(changes), 1);
    check("d_latency_ok", 32'(lat >= 3 && lat <= 4), 1);
    check("d_byte1", 32'(dout0), 32'h09);
    repeat (4) @(negedge clk);
    k = 0;
    while (avail0 && k < 10) begin
      strobe();
      k++;
    end
    check("d_drain_count", 32'(k), 7);
    check("d_drain_avail", 32'(avail0), 0);

    // One-cycle glitch while idle must change nothing.
    host_rd = 1'b1;
    @(negedge clk);
    host_rd = 1'b0;
    repeat (6) @(negedge clk);
    check("e_ready", 32'(bus0.res_ready), 1);
    check("e_avail", 32'(avail0), 0);
    check("e_dout", 32'(dout0), 0);
    bus0.res_valid = 1'b1;
    bus0.res_data  = 64'h0000_0000_0000_0042;
    @(negedge clk);
    bus0.res_valid = 1'b0;
    check("e_new_byte0", 32'(dout0), 32'h42);
    check("e_new_last", 32'(last0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
